// File: rtl/memory_fill_responder.sv
// ---------------------------------------------------------------------------
// memory_fill_responder
//
// Pipelined main-memory responder used by the cache fill engine. It accepts
// one word request per cycle from the memory arbiter. A write commits to the
// backing store at the request edge and produces no response. A read samples
// the store at the request edge and returns that word LATENCY cycles later as
// a one-cycle data_valid pulse. Reads may be issued on every cycle. Their
// responses come back in issue order, one per cycle, with no gaps.
//
// Ports
//   clk        : single clock; all state updates on the rising edge
//   rst        : asynchronous active-high reset (pipeline control only)
//   enable     : request strobe, sampled every rising edge
//   wr         : 1 = write, 0 = read (qualified by enable)
//   addr       : byte address; word index = addr[ADDR_WIDTH-1:1]
//   data_in    : write data
//   data_out   : read data, forced to zero whenever data_valid = 0
//   data_valid : one-cycle pulse per completed read
//   busy       : 1 while any read is in flight
//   align_err  : (MEM_ALIGN_CHECK_EN only) pulses one cycle after any enabled
//                request with addr[0] = 1
//
// Configuration
//   MEM_ALIGN_CHECK_EN : when defined, adds align_err. Misaligned writes are
//                        dropped. Misaligned reads still return the aligned
//                        word. When undefined, addr[0] is ignored.
//
// The store is not reset. Its contents are whatever was loaded or written.
// ---------------------------------------------------------------------------
module memory_fill_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LATENCY    = 4,
  parameter int MEM_WORDS  = 32768
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [15:0]           data_in,
  output logic [15:0]           data_out,
  output logic                  data_valid,
  output logic                  busy
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic                  align_err
`endif
);

  localparam int DATA_W = 16;
  localparam int WIDX_W = ADDR_WIDTH - 1;

  // Backing word store
  logic [DATA_W-1:0] mem [0:MEM_WORDS-1];

  logic [WIDX_W-1:0] word_idx;
  logic              rd_req;
  logic              wr_req;

  assign word_idx = addr[ADDR_WIDTH-1:1];
  assign rd_req   = enable & ~wr;

`ifdef MEM_ALIGN_CHECK_EN
  // Misaligned writes are dropped so that a partial-word write cannot corrupt
  // the aligned word.
  assign wr_req = enable & wr & ~addr[0];
`else
  logic unused_addr_lsb;
  assign unused_addr_lsb = addr[0];
  assign wr_req = enable & wr;
`endif

  // Read and write never coincide, so the write needs no forwarding path.
  // A read at edge N sees every write committed at or before edge N-1.
  always_ff @(posedge clk) begin
    if (wr_req) begin
      mem[word_idx] <= data_in;
    end
  end

  // --------------------------------------------------------------------------
  // Response pipeline: entry 0 is loaded at the request edge.
  // Entry LATENCY-1 drives the outputs.
  // --------------------------------------------------------------------------
  logic [LATENCY-1:0] vld_pipe_q;
  logic [LATENCY-1:0] vld_pipe_d;
  logic [DATA_W-1:0]  dat_pipe_q [LATENCY];
  logic [DATA_W-1:0]  dat_pipe_d [LATENCY];

  always_comb begin
    vld_pipe_d    = '0;
    dat_pipe_d    = '{default: '0};
    vld_pipe_d[0] = rd_req;
    // Read data is captured at issue. A later write to the same word cannot
    // change a read that is already in flight.
    dat_pipe_d[0] = mem[word_idx];
    for (int i = 1; i < LATENCY; i++) begin
      vld_pipe_d[i] = vld_pipe_q[i-1];
      dat_pipe_d[i] = dat_pipe_q[i-1];
    end
  end

  // Control: the valid bits are cleared by reset, so reads in flight are lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
    end
  end

  // Data: no reset needed. The output mask below hides stale contents.
  always_ff @(posedge clk) begin
    dat_pipe_q <= dat_pipe_d;
  end

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  assign data_valid = vld_pipe_q[LATENCY-1];
  assign data_out   = data_valid ? dat_pipe_q[LATENCY-1] : '0;
  assign busy       = |vld_pipe_q;

`ifdef MEM_ALIGN_CHECK_EN
  logic align_err_q;
  logic align_err_d;

  always_comb begin
    align_err_d = enable & addr[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      align_err_q <= 1'b0;
    end else begin
      align_err_q <= align_err_d;
    end
  end

  assign align_err = align_err_q;
`endif

endmodule

// File: tb/tb_memory_fill_responder.sv
module tb_memory_fill_responder;

  localparam int LAT   = 4;
  localparam int WORDS = 32768;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] data_in = '0;
  logic [15:0] data_out;
  logic        data_valid;
  logic        busy;
`ifdef MEM_ALIGN_CHECK_EN
  logic        align_err;
`endif

  always #5 clk = ~clk;

  memory_fill_responder #(
    .ADDR_WIDTH(16),
    .LATENCY   (LAT),
    .MEM_WORDS (WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .wr        (wr),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .data_valid(data_valid),
    .busy      (busy)
`ifdef MEM_ALIGN_CHECK_EN
    ,
    .align_err (align_err)
`endif
  );

  // Reference model: a word array plus a queue of responses due at given cycles.
  typedef struct {
    int          due;
    logic [15:0] d;
  } rsp_t;

  rsp_t        pend[$];
  logic [15:0] mem_m [WORDS];
  int          cyc = 0;
  logic        exp_valid = 1'b0;
  logic        exp_busy = 1'b0;
  logic [15:0] exp_data = '0;
  logic        exp_align = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Applies one request across one rising edge and advances the model.
  task automatic step(input logic en, input logic w, input logic [15:0] a, input logic [15:0] d);
    rsp_t r;
    enable  = en;
    wr      = w;
    addr    = a;
    data_in = d;
    @(posedge clk);
    cyc++;
    if (en) begin
      if (w) begin
`ifdef MEM_ALIGN_CHECK_EN
        if (!a[0]) mem_m[a[15:1]] = d;
`else
        mem_m[a[15:1]] = d;
`endif
      end else begin
        r.due = cyc + LAT - 1;
        r.d   = mem_m[a[15:1]];
        pend.push_back(r);
      end
    end
    if (rst) pend.delete();
    exp_align = !rst && en && a[0];
    #1;
    exp_busy  = (pend.size() > 0);
    exp_valid = 1'b0;
    exp_data  = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_valid = 1'b1;
      exp_data  = pend[0].d;
      void'(pend.pop_front());
    end
  endtask

  task automatic test_reset();
    int pulses;
    logic [15:0] v;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (data_valid !== 1'b0 || data_out !== 16'h0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_init: got v=%b d=%h b=%b, want v=0 d=0000 b=0", data_valid, data_out, busy);
    end
    for (int i = 0; i < WORDS; i++) begin
      v = 16'($urandom);
      dut.mem[i] = v;
      mem_m[i] = v;
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    // Two reads in flight, then an asynchronous reset pulse.
    step(1'b1, 1'b0, 16'h0040, 16'h0);
    step(1'b1, 1'b0, 16'h0042, 16'h0);
    step(1'b0, 1'b0, 16'h0, 16'h0);
    n_cmp++;
    if (busy !== exp_busy || exp_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_busy_before: got b=%b, want b=1", busy);
    end
    #2 rst = 1'b1;
    #1;
    pend.delete();
    n_cmp++;
    if (data_valid !== 1'b0 || data_out !== 16'h0000 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_async: got v=%b d=%h b=%b, want v=0 d=0000 b=0", data_valid, data_out, busy);
    end
    step(1'b0, 1'b0, 16'h0, 16'h0);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 16'h0, 16'h0);
      if (data_valid === 1'b1) pulses++;
      n_cmp++;
      if (data_valid !== exp_valid || data_out !== exp_data || busy !== exp_busy) begin
        n_bad++;
        $display("FAIL reset_idle cyc=%0d: got v=%b d=%h b=%b, want v=%b d=%h b=%b",
                 cyc, data_valid, data_out, busy, exp_valid, exp_data, exp_busy);
      end
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL reset_no_late_pulse: got %0d pulses, want 0", pulses);
    end
  endtask

  task automatic test_write_read();
    int first_at = -1;
    int busy_cnt;
    logic [15:0] got = '0;
    step(1'b1, 1'b1, 16'h0010, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0010, 16'h0);
    busy_cnt = busy ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 16'h0, 16'h0);
      n_cmp++;
      if (data_valid !== exp_valid || data_out !== exp_data || busy !== exp_busy) begin
        n_bad++;
        $display("FAIL write_read cyc=%0d: got v=%b d=%h b=%b, want v=%b d=%h b=%b",
                 cyc, data_valid, data_out, busy, exp_valid, exp_data, exp_busy);
      end
      if (data_valid === 1'b1 && first_at < 0) begin
        first_at = i;
        got = data_out;
      end
      if (busy === 1'b1) busy_cnt++;
    end
    n_cmp++;
    if (first_at !== LAT - 2 || got !== 16'hBEEF) begin
      n_bad++;
      $display("FAIL write_read_latency: got idle_idx=%0d d=%h, want idle_idx=%0d d=beef", first_at, got, LAT - 2);
    end
    n_cmp++;
    if (busy_cnt !== LAT) begin
      n_bad++;
      $display("FAIL write_read_busy: got %0d busy cycles, want %0d", busy_cnt, LAT);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] seen[$];
    int first_cyc = -1;
    int last_cyc = -1;
    int req_cyc;
    for (int i = 0; i < 8; i++) begin
      dut.mem[i] = 16'h1000 + 16'(i);
      mem_m[i] = 16'h1000 + 16'(i);
    end
    for (int i = 0; i < 14; i++) begin
      if (i < 8) step(1'b1, 1'b0, 16'(i * 2), 16'h0);
      else       step(1'b0, 1'b0, 16'h0, 16'h0);
      if (i == 0) req_cyc = cyc;
      n_cmp++;
      if (data_valid !== exp_valid || data_out !== exp_data || busy !== exp_busy) begin
        n_bad++;
        $display("FAIL burst cyc=%0d: got v=%b d=%h b=%b, want v=%b d=%h b=%b",
                 cyc, data_valid, data_out, busy, exp_valid, exp_data, exp_busy);
      end
      if (data_valid === 1'b1) begin
        seen.push_back(data_out);
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
      end
    end
    n_cmp++;
    if (seen.size() !== 8 || first_cyc - req_cyc !== LAT - 1 || last_cyc - first_cyc !== 7) begin
      n_bad++;
      $display("FAIL burst_shape: got n=%0d start=%0d span=%0d, want n=8 start=%0d span=7",
               seen.size(), first_cyc - req_cyc, last_cyc - first_cyc, LAT - 1);
    end
    for (int k = 0; k < seen.size(); k++) begin
      n_cmp++;
      if (seen[k] !== 16'h1000 + 16'(k)) begin
        n_bad++;
        $display("FAIL burst_order[%0d]: got %h, want %h", k, seen[k], 16'h1000 + 16'(k));
      end
    end
  endtask

  task automatic test_capture();
    logic [15:0] seen[$];
    dut.mem[16'h0010] = 16'h1111;
    mem_m[16'h0010] = 16'h1111;
    for (int i = 0; i < 9; i++) begin
      case (i)
        0:       step(1'b1, 1'b0, 16'h0020, 16'h0);
        1:       step(1'b1, 1'b1, 16'h0020, 16'h2222);
        2:       step(1'b1, 1'b0, 16'h0020, 16'h0);
        default: step(1'b0, 1'b0, 16'h0, 16'h0);
      endcase
      n_cmp++;
      if (data_valid !== exp_valid || data_out !== exp_data || busy !== exp_busy) begin
        n_bad++;
        $display("FAIL capture cyc=%0d: got v=%b d=%h b=%b, want v=%b d=%h b=%b",
                 cyc, data_valid, data_out, busy, exp_valid, exp_data, exp_busy);
      end
      if (data_valid === 1'b1) seen.push_back(data_out);
    end
    n_cmp++;
    if (seen.size() !== 2 || seen[0] !== 16'h1111 || seen[1] !== 16'h2222) begin
      n_bad++;
      $display("FAIL capture_values: got n=%0d, want 1111 then 2222", seen.size());
    end
  endtask

  task automatic test_align();
    logic [15:0] seen[$];
    logic [15:0] want2;
    dut.mem[16'h0010] = 16'hA5A5;
    mem_m[16'h0010] = 16'hA5A5;
    dut.mem[16'h0018] = 16'h3030;
    mem_m[16'h0018] = 16'h3030;
`ifdef MEM_ALIGN_CHECK_EN
    want2 = 16'h3030;
`else
    want2 = 16'hDEAD;
`endif
    for (int i = 0; i < 10; i++) begin
      case (i)
        0:       step(1'b1, 1'b0, 16'h0021, 16'h0);
        2:       step(1'b1, 1'b1, 16'h0031, 16'hDEAD);
        3:       step(1'b1, 1'b0, 16'h0030, 16'h0);
        default: step(1'b0, 1'b0, 16'h0, 16'h0);
      endcase
      n_cmp++;
      if (data_valid !== exp_valid || data_out !== exp_data || busy !== exp_busy) begin
        n_bad++;
        $display("FAIL align cyc=%0d: got v=%b d=%h b=%b, want v=%b d=%h b=%b",
                 cyc, data_valid, data_out, busy, exp_valid, exp_data, exp_busy);
      end
`ifdef MEM_ALIGN_CHECK_EN
      n_cmp++;
      if (align_err !== exp_align) begin
        n_bad++;
        $display("FAIL align_err cyc=%0d: got %b, want %b", cyc, align_err, exp_align);
      end
`endif
      if (data_valid === 1'b1) seen.push_back(data_out);
    end
    n_cmp++;
    if (seen.size() !== 2 || seen[0] !== 16'hA5A5 || seen[1] !== want2) begin
      n_bad++;
      $display("FAIL align_values: got n=%0d, want a5a5 then %h", seen.size(), want2);
    end
  endtask

  task automatic test_random();
    logic        en;
    logic        w;
    logic [15:0] a;
    for (int i = 0; i < 410; i++) begin
      en = (i < 400) && ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 9) < 4);
      a  = 16'($urandom_range(0, 127));
      step(en, w, a, 16'($urandom));
      n_cmp++;
      if (data_valid !== exp_valid || data_out !== exp_data || busy !== exp_busy) begin
        n_bad++;
        $display("FAIL random cyc=%0d: got v=%b d=%h b=%b, want v=%b d=%h b=%b",
                 cyc, data_valid, data_out, busy, exp_valid, exp_data, exp_busy);
      end
`ifdef MEM_ALIGN_CHECK_EN
      n_cmp++;
      if (align_err !== exp_align) begin
        n_bad++;
        $display("FAIL random_align cyc=%0d: got %b, want %b", cyc, align_err, exp_align);
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_capture();
    test_align();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
